// File: rtl/draw_fill.sv
// Rectangle fill engine: writes a solid ARGB8888 colour into a VRAM rectangle over AXI AW/W/B.
// Optional DRAW_FILL_IRQ_EN macro enables the CTRL.INTENB bit and the level DRAW_IRQ output.
module draw_fill #(
  parameter int          C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int          C_M_AXI_ADDR_WIDTH      = 32,
  parameter int          C_M_AXI_DATA_WIDTH      = 64,
  parameter logic [15:0] REG_BASE                = 16'h3000
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [15:0]                        WRADDR,
  input  logic [3:0]                         BYTEEN,
  input  logic                               WREN,
  input  logic [31:0]                        WDATA,
  input  logic [15:0]                        RDADDR,
  input  logic                               RDEN,
  output logic [31:0]                        RDATA,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic [1:0]                         M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic                               M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic                               M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY,
  output logic                               DRAW_BUSY,
  output logic                               DRAW_IRQ,
  output logic [2:0]                         state_dbg
);

  // Handshakes: a transfer happens on the ACLK edge where valid and ready are both high;
  // the source holds valid and its payload unchanged until then, ready may toggle freely.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AW, S_W, S_B, S_FIN} state_t;
  state_t state_q, state_d;

  logic [31:0] drawaddr_r, stride_r, pos_r, size_r, color_r;
  logic        done_q, berr_q, intenb_q;
  logic [28:0] line_addr, cur_addr, y_off, first_addr, stride29;
  logic [9:0]  beats_left, left_m1, step;
  logic [10:0] lines_left;
  logic [3:0]  awlen_q, awlen_d, room_m1, beat_cnt;
  logic [31:0] bmask;
  logic        busy, cfg_wr, ctrl_wr, status_wr, start_req, start_go, last_beat;

  assign bmask     = {{8{BYTEEN[3]}}, {8{BYTEEN[2]}}, {8{BYTEEN[1]}}, {8{BYTEEN[0]}}};
  assign busy      = (state_q == S_SETUP) || (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
  assign cfg_wr    = WREN && !busy;
  assign ctrl_wr   = WREN && (WRADDR == REG_BASE + 16'h14);
  assign status_wr = WREN && (WRADDR == REG_BASE + 16'h18);
  assign start_req = ctrl_wr && BYTEEN[0] && WDATA[0];
  assign start_go  = start_req && ((state_q == S_IDLE) || (state_q == S_FIN));

  assign stride29   = {13'd0, stride_r[15:3], 3'd0};
  assign y_off      = {18'd0, pos_r[26:16]} * {13'd0, stride_r[15:0]};
  assign first_addr = drawaddr_r[28:0] + y_off + {16'd0, pos_r[10:1], 3'd0};

  // Burst stops at the next 128-byte boundary or at the end of the line, whichever is first.
  assign room_m1   = 4'd15 - cur_addr[6:3];
  assign left_m1   = beats_left - 10'd1;
  assign awlen_d   = (left_m1 < {6'd0, room_m1}) ? left_m1[3:0] : room_m1;
  assign step      = {6'd0, awlen_q} + 10'd1;
  assign last_beat = (beat_cnt == awlen_q);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] fmask,
                                        input logic [31:0] be, input logic [31:0] wd);
    merge = (old & ~(fmask & be)) | (wd & fmask & be);
  endfunction

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_req) state_d = S_SETUP;
      S_SETUP: state_d = ((beats_left == 10'd0) || (lines_left == 11'd0)) ? S_FIN : S_AW;
      S_AW:    if (M_AXI_AWREADY) state_d = S_W;
      S_W:     if (M_AXI_WREADY && last_beat) state_d = S_B;
      S_B:     if (M_AXI_BVALID) state_d = S_SETUP;
      S_FIN:   state_d = start_req ? S_SETUP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      drawaddr_r <= '0; stride_r <= '0; pos_r <= '0; size_r <= '0; color_r <= '0;
      done_q <= 1'b0; berr_q <= 1'b0;
      line_addr <= '0; cur_addr <= '0; beats_left <= '0; lines_left <= '0;
      awlen_q <= '0; beat_cnt <= '0;
    end else begin
      if (cfg_wr) begin
        case (WRADDR)
          REG_BASE + 16'h00: drawaddr_r <= merge(drawaddr_r, 32'h1FFF_FFF8, bmask, WDATA);
          REG_BASE + 16'h04: stride_r   <= merge(stride_r,   32'h0000_FFF8, bmask, WDATA);
          REG_BASE + 16'h08: pos_r      <= merge(pos_r,      32'h07FF_07FF, bmask, WDATA);
          REG_BASE + 16'h0C: size_r     <= merge(size_r,     32'h07FF_07FF, bmask, WDATA);
          REG_BASE + 16'h10: color_r    <= merge(color_r,    32'hFFFF_FFFF, bmask, WDATA);
          default: ;
        endcase
      end
      if (status_wr && BYTEEN[0] && WDATA[1]) done_q <= 1'b0;
      if (status_wr && BYTEEN[0] && WDATA[2]) berr_q <= 1'b0;
      // Set after the clear so a completion in the same cycle is not lost.
      if (state_q == S_SETUP && state_d == S_FIN) done_q <= 1'b1;
      if (state_q == S_B && M_AXI_BVALID && M_AXI_BRESP != 2'b00) berr_q <= 1'b1;
      if (start_go) begin
        line_addr  <= first_addr;
        cur_addr   <= first_addr;
        beats_left <= size_r[10:1];
        lines_left <= size_r[26:16];
      end
      case (state_q)
        S_SETUP: awlen_q <= awlen_d;
        S_AW:    if (M_AXI_AWREADY) beat_cnt <= '0;
        S_W:     if (M_AXI_WREADY) beat_cnt <= beat_cnt + 4'd1;
        S_B: if (M_AXI_BVALID) begin
          if (beats_left == step) begin
            lines_left <= lines_left - 11'd1;
            line_addr  <= line_addr + stride29;
            cur_addr   <= line_addr + stride29;
            beats_left <= size_r[10:1];
          end else begin
            beats_left <= beats_left - step;
            cur_addr   <= cur_addr + {16'd0, step, 3'd0};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DRAW_FILL_IRQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                    intenb_q <= 1'b0;
    else if (ctrl_wr && BYTEEN[0])   intenb_q <= WDATA[1];
  end
  assign DRAW_IRQ = done_q & intenb_q;
`else
  assign intenb_q = 1'b0;
  assign DRAW_IRQ = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) RDATA <= '0;
    else if (RDEN) begin
      case (RDADDR)
        REG_BASE + 16'h00: RDATA <= drawaddr_r;
        REG_BASE + 16'h04: RDATA <= stride_r;
        REG_BASE + 16'h08: RDATA <= pos_r;
        REG_BASE + 16'h0C: RDATA <= size_r;
        REG_BASE + 16'h10: RDATA <= color_r;
        REG_BASE + 16'h14: RDATA <= {30'd0, intenb_q, 1'b0};
        REG_BASE + 16'h18: RDATA <= {29'd0, berr_q, done_q, busy};
        default:           RDATA <= '0;
      endcase
    end
  end

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = {3'b001, cur_addr};
  assign M_AXI_AWLEN   = {4'd0, awlen_q};
  assign M_AXI_AWSIZE  = 3'b011;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 2'b00;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 1'b0;
  assign M_AXI_AWVALID = (state_q == S_AW);
  assign M_AXI_WDATA   = {color_r, color_r};
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (state_q == S_W) && last_beat;
  assign M_AXI_WUSER   = 1'b0;
  assign M_AXI_WVALID  = (state_q == S_W);
  assign M_AXI_BREADY  = (state_q == S_B);
  assign DRAW_BUSY     = busy;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_draw_fill.sv
// Directed bench for draw_fill: register access, fills against an AXI slave model, timing,
// backpressure, error response, degenerate sizes and reset abort.
module tb_draw_fill;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [15:0] WRADDR = '0, RDADDR = '0;
  logic [3:0]  BYTEEN = '0;
  logic        WREN = 1'b0, RDEN = 1'b0;
  logic [31:0] WDATA = '0, RDATA;
  logic [0:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE, M_AXI_AWPROT, state_dbg;
  logic [1:0]  M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_BRESP;
  logic [3:0]  M_AXI_AWCACHE, M_AXI_AWQOS;
  logic        M_AXI_AWUSER, M_AXI_AWVALID, M_AXI_AWREADY;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, DRAW_BUSY, DRAW_IRQ;

  draw_fill dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .DRAW_BUSY(DRAW_BUSY), .DRAW_IRQ(DRAW_IRQ), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [39:0] exp_q[$];          // {AWADDR, AWLEN}
  logic [63:0] exp_wdata;
  int beats_seen = 0, aw_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int   aw_stall_cfg = 0, aw_wait = 0, burst_idx = 0, beat_idx = 0, beat_last = 0, b_cyc = 0;
  bit   w_toggle = 0, err_first = 0, tog = 0;
  bit   b_pending = 0, b_fire = 0, b_cyc_valid = 0, aw_prev = 0, aw_stalled = 0, w_stalled = 0;
  logic [39:0] aw_prev_val;
  logic [63:0] w_prev_data;
  logic [1:0]  cur_bresp = 2'b00;
  logic [39:0] want;

  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        b_pending = 0; b_fire = 0; b_cyc_valid = 0; aw_prev = 0; aw_stalled = 0; w_stalled = 0;
      end else begin
        if (b_fire) begin M_AXI_BVALID = 0; b_fire = 0; end
        if (b_pending && !M_AXI_BVALID) begin M_AXI_BVALID = 1; M_AXI_BRESP = cur_bresp; b_pending = 0; end
        if (M_AXI_BVALID && M_AXI_BREADY) begin b_fire = 1; b_cyc = cyc; b_cyc_valid = 1; end

        if (M_AXI_AWVALID) begin
          if (!aw_prev && b_cyc_valid) begin check("aw_after_b", cyc - b_cyc, 2); b_cyc_valid = 0; end
          if (aw_stalled) check("aw_stable", {M_AXI_AWADDR, M_AXI_AWLEN}, aw_prev_val);
          if (aw_wait > 0) begin
            M_AXI_AWREADY = 0; aw_wait--; aw_stalled = 1; aw_prev_val = {M_AXI_AWADDR, M_AXI_AWLEN};
          end else begin
            M_AXI_AWREADY = 1; aw_stalled = 0; aw_wait = aw_stall_cfg; aw_count++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("aw_burst", {M_AXI_AWADDR, M_AXI_AWLEN}, want);
            beat_idx = 0; beat_last = M_AXI_AWLEN;
            cur_bresp = (err_first && burst_idx == 0) ? 2'b10 : 2'b00;
            burst_idx++;
          end
        end else M_AXI_AWREADY = 0;
        aw_prev = M_AXI_AWVALID;

        if (w_stalled) begin
          check("w_valid_held", M_AXI_WVALID, 1);
          check("w_data_held", M_AXI_WDATA, w_prev_data);
        end
        if (M_AXI_WVALID) begin
          tog = ~tog;
          M_AXI_WREADY = w_toggle ? tog : 1'b1;
          check("w_last", M_AXI_WLAST, beat_idx == beat_last);
          if (M_AXI_WREADY) begin
            check("w_data", M_AXI_WDATA, exp_wdata);
            beat_idx++; beats_seen++; w_stalled = 0;
            if (M_AXI_WLAST) b_pending = 1;
          end else begin
            w_stalled = 1; w_prev_data = M_AXI_WDATA;
          end
        end else begin
          M_AXI_WREADY = 0; w_stalled = 0;
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  task automatic reg_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be = 4'hF);
    WRADDR = 16'h3000 + {8'd0, off}; WDATA = d; BYTEEN = be; WREN = 1;
    @(negedge ACLK);
    WREN = 0;
  endtask

  task automatic reg_rd(input logic [7:0] off, output logic [31:0] d);
    RDADDR = 16'h3000 + {8'd0, off}; RDEN = 1;
    @(negedge ACLK);
    RDEN = 0; d = RDATA;
  endtask

  task automatic config_fill(input logic [31:0] base, input logic [31:0] stride,
                             input logic [31:0] pos, input logic [31:0] size, input logic [31:0] color);
    reg_wr(8'h00, base); reg_wr(8'h04, stride); reg_wr(8'h08, pos);
    reg_wr(8'h0C, size); reg_wr(8'h10, color);
    exp_wdata = {color, color};
    exp_q.delete(); beats_seen = 0; burst_idx = 0; aw_wait = aw_stall_cfg; b_cyc_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (DRAW_BUSY && n < budget) begin @(negedge ACLK); n++; end
    check("done_in_budget", DRAW_BUSY, 0);
  endtask

  task automatic finish_fill(input string tag, input int beats, input logic [31:0] status);
    logic [31:0] rd;
    wait_idle(2000);
    check({tag, "_done_after_b"}, cyc - b_cyc, 2);
    b_cyc_valid = 0;
    check({tag, "_bursts_left"}, exp_q.size(), 0);
    check({tag, "_beats"}, beats_seen, beats);
    reg_rd(8'h18, rd);
    check({tag, "_status"}, rd, status);
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] rd;
  int aw_before;

  initial begin
    @(negedge ACLK);
    repeat (3) @(negedge ACLK);
    check("reset_outputs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
                            DRAW_BUSY, DRAW_IRQ, RDATA}, 0);
    ARESETN = 1;
    @(negedge ACLK);
    reg_rd(8'h18, rd); check("reset_status", rd, 0);
    reg_rd(8'h10, rd); check("reset_color", rd, 0);

    // register field masks and byte enables
    reg_wr(8'h00, 32'hFFFF_FFFF); reg_rd(8'h00, rd); check("drawaddr_mask", rd, 32'h1FFF_FFF8);
    reg_wr(8'h04, 32'hFFFF_FFFF); reg_rd(8'h04, rd); check("stride_mask", rd, 32'h0000_FFF8);
    reg_wr(8'h08, 32'hFFFF_FFFF); reg_rd(8'h08, rd); check("pos_mask", rd, 32'h07FF_07FF);
    reg_wr(8'h10, 32'h1234_5678, 4'b0101); reg_rd(8'h10, rd); check("color_byteen", rd, 32'h0034_0078);
    reg_wr(8'h14, 32'h2); reg_rd(8'h14, rd);
`ifdef DRAW_FILL_IRQ_EN
    check("ctrl_intenb", rd, 32'h2);
`else
    check("ctrl_intenb", rd, 32'h0);
`endif
    reg_wr(8'h14, 32'h0);

    // normal fill: two lines of 16 beats
    aw_stall_cfg = 0; w_toggle = 0; err_first = 0;
    config_fill(32'h0, 32'h1000, 32'h0, 32'h0002_0020, 32'hFF00_FF00);
    exp_q.push_back({32'h2000_0000, 8'd15});
    exp_q.push_back({32'h2000_1000, 8'd15});
    reg_wr(8'h14, 32'h1);
    check("start_busy", {DRAW_BUSY, M_AXI_AWVALID}, 2'b10);
    @(negedge ACLK);
    check("start_awvalid", M_AXI_AWVALID, 1);
    reg_wr(8'h10, 32'h0);             // ignored while busy
    finish_fill("normal", 32, 32'h2);
    reg_rd(8'h10, rd); check("color_kept", rd, 32'hFF00_FF00);
    repeat (3) @(negedge ACLK);
    check("rdata_hold", RDATA, 32'hFF00_FF00);
    reg_wr(8'h18, 32'h2);

    // 128-byte boundary split
    config_fill(32'h0, 32'h1000, 32'h0000_001E, 32'h0001_0008, 32'h0102_0304);
    exp_q.push_back({32'h2000_0078, 8'd0});
    exp_q.push_back({32'h2000_0080, 8'd2});
    reg_wr(8'h14, 32'h1);
    finish_fill("split", 4, 32'h2);
    reg_wr(8'h18, 32'h2);

    // degenerate sizes: DONE two cycles after START, no address phase
    for (int t = 0; t < 2; t++) begin
      config_fill(32'h0, 32'h1000, 32'h0, (t == 0) ? 32'h0004_0001 : 32'h0000_0020, 32'h5);
      aw_before = aw_count;
      reg_wr(8'h14, 32'h1);
      reg_rd(8'h18, rd); check("degen_status_n1", rd, 32'h1);
      reg_rd(8'h18, rd); check("degen_status_n2", rd, 32'h2);
      repeat (4) @(negedge ACLK);
      check("degen_no_aw", aw_count, aw_before);
      reg_wr(8'h18, 32'h2);
    end

    // backpressure: AWREADY late, WREADY toggling
    aw_stall_cfg = 5; w_toggle = 1;
    config_fill(32'h0, 32'h1000, 32'h0, 32'h0001_0028, 32'hCAFE_BABE);
    exp_q.push_back({32'h2000_0000, 8'd15});
    exp_q.push_back({32'h2000_0080, 8'd3});
    reg_wr(8'h14, 32'h1);
    finish_fill("bp", 20, 32'h2);
    reg_wr(8'h18, 32'h2);
    aw_stall_cfg = 0; w_toggle = 0;

    // error response on the first burst, interrupt
    err_first = 1;
    config_fill(32'h0, 32'h1000, 32'h0, 32'h0002_0020, 32'h0F0F_0F0F);
    exp_q.push_back({32'h2000_0000, 8'd15});
    exp_q.push_back({32'h2000_1000, 8'd15});
    reg_wr(8'h14, 32'h3);
    finish_fill("berr", 32, 32'h6);
`ifdef DRAW_FILL_IRQ_EN
    check("irq_set", DRAW_IRQ, 1);
`else
    check("irq_set", DRAW_IRQ, 0);
`endif
    reg_wr(8'h18, 32'h2);
    check("irq_clear", DRAW_IRQ, 0);
    reg_rd(8'h18, rd); check("berr_stays", rd, 32'h4);
    reg_wr(8'h18, 32'h4);
    reg_rd(8'h18, rd); check("berr_clear", rd, 32'h0);
    err_first = 0;

    // reset during the data phase, then a fresh fill
    config_fill(32'h0, 32'h1000, 32'h0, 32'h0001_0020, 32'h1111_2222);
    exp_q.push_back({32'h2000_0000, 8'd15});
    reg_wr(8'h14, 32'h1);
    for (int i = 0; i < 50 && !M_AXI_WVALID; i++) @(negedge ACLK);
    check("abort_in_w", M_AXI_WVALID, 1);
    @(negedge ACLK);
    #2 ARESETN = 0;
    #1 check("abort_outputs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, DRAW_BUSY}, 0);
    @(negedge ACLK); @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    reg_rd(8'h10, rd); check("abort_regs_cleared", rd, 0);
    config_fill(32'h40, 32'h1000, 32'h0, 32'h0001_0008, 32'hABCD_EF01);
    exp_q.push_back({32'h2000_0040, 8'd3});
    reg_wr(8'h14, 32'h1);
    finish_fill("after_abort", 4, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
